divide_f32: RTL and testbench
=============================

DIVIDE_F32 -- requirements
Module: divide_f32

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 32-bit IEEE-754 single precision.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high; it also serves as the start/load strobe.
REQ-004 num  input  32  dividend, IEEE-754 single.
REQ-005 den  input  32  divisor, IEEE-754 single.
REQ-006 rdy  output  1  registered; 1 = quo valid.
REQ-007 quo  output  32  registered quotient num/den.

Function
REQ-008 SHALL capture num and den into internal registers on every rising edge where rst=1; input changes while rst=0 SHALL be ignored.
REQ-009 States SHALL be SETUP, DIVIDE, NORM and DONE; rst=1 SHALL force SETUP.
REQ-010 SETUP (1 cycle) SHALL decode sign = num[31] XOR den[31], exponents, hidden-bit mantissas and special cases, then go to DIVIDE.
REQ-011 DIVIDE SHALL run restoring mantissa division, 1 quotient bit per cycle, for 26 cycles (q[25:0], 1 integer bit, 25 fraction bits), keeping the remainder, then go to NORM.
REQ-012 NORM (1 cycle) SHALL normalize, round and pack.
- If q[25]=1: mantissa=q[24:2], guard=q[1], sticky=q[0]|(rem!=0), biased exp=ea-eb+127.
- Else: mantissa=q[23:1], guard=q[0], sticky=(rem!=0), exp=ea-eb+126.
REQ-013 Exponent arithmetic SHALL use a signed 10-bit intermediate.
- Result >=255: signed infinity.
- Result <=0: signed zero (flush; no subnormal outputs).
REQ-014 Latency SHALL be fixed for all inputs, including special cases: rdy and quo update together on the 28th rising edge with rst=0 after the last rst=1 edge.
REQ-015 In DONE, rdy=1 and quo SHALL hold until the next rst=1 edge.
REQ-016 rdy SHALL be 0 in every other state.
REQ-017 Inputs with exponent 0 (zero/subnormal) SHALL be treated as signed zero.
REQ-018 Special-case results:
- NaN input, 0/0, inf/inf: 0x7FC00000.
- finite/0 and inf/finite: signed inf.
- 0/finite and finite/inf: signed zero.
REQ-019 Reasserting rst mid-operation SHALL abort; rdy=0 after that edge and the new operands restart at SETUP.

Reset
REQ-020 On a rising edge with rst=1: rdy=0, quo=32'h0, quotient and remainder registers cleared, state=SETUP, operands captured.
REQ-021 No asynchronous reset paths SHALL exist.

Configuration
REQ-022 Macro DIVIDE_F32_RNE_EN:
- Defined: round-to-nearest-even using guard/sticky. A mantissa carry-out increments the exponent and may produce infinity.
- Undefined: truncation toward zero (guard/sticky discarded).
- Latency is identical in both builds.

Verification
REQ-023 num=0x40C00000, den=0x40000000 -> quo=0x40400000, rdy rising exactly 28 edges after rst deasserts.
REQ-024 num=0x3F800000, den=0x40400000 -> quo=0x3EAAAAAB with DIVIDE_F32_RNE_EN, 0x3EAAAAAA without.
REQ-025 num=0xC1000000, den=0x3F000000 -> quo=0xC1800000.
REQ-026 num=0x3F800000, den=0x00000000 -> quo=0x7F800000; num=0, den=0 -> quo=0x7FC00000; num=0x7F000000, den=0x3E800000 -> quo=0x7F800000.
REQ-027 Start 6/2, reassert rst 10 cycles later with 1/3 loaded -> rdy stays 0 throughout; 28 cycles after the second release, 1/3 result appears and holds while num/den are toggled.

Source files
------------

// File: rtl/divide_f32.sv
// IEEE-754 single-precision divider: restoring mantissa division, fixed 28-cycle latency.
// Optional macro DIVIDE_F32_RNE_EN selects round-to-nearest-even; otherwise results truncate.
module divide_f32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] num,
    input  logic [31:0] den,
    output logic        rdy,
    output logic [31:0] quo
);

    typedef enum logic [1:0] {StSetup, StDivide, StNorm, StDone} state_e;

    state_e             state_q, state_d;
    logic        [31:0] num_q, den_q;
    logic               sign_q, sign_d;
    logic               spec_q, spec_d;
    logic        [31:0] spec_val_q, spec_val_d;
    logic signed [9:0]  exp_q, exp_d;
    logic        [23:0] mb_q, mb_d;
    logic        [24:0] rem_q, rem_d;
    logic        [25:0] q_q, q_d;
    logic        [4:0]  cnt_q, cnt_d;
    logic               rdy_q, rdy_d;
    logic        [31:0] quo_q, quo_d;

    // Operand decode
    logic [7:0] ea, eb;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    always_comb begin
        ea     = num_q[30:23];
        eb     = den_q[30:23];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (num_q[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (den_q[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (num_q[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (den_q[22:0] != 23'd0);
    end

    // One restoring-division step
    logic        sub_ok;
    logic [24:0] diff;

    always_comb begin
        sub_ok = (rem_q >= {1'b0, mb_q});
        diff   = rem_q - {1'b0, mb_q};
    end

    // Normalize, round and pack
    logic        [22:0] mant;
    logic        [23:0] mant_r;
    logic signed [9:0]  e_n, e_r;
    logic               round_up;
    logic        [31:0] packed_res;
`ifdef DIVIDE_F32_RNE_EN
    logic               guard, sticky;
`endif

    always_comb begin
        if (q_q[25]) begin
            mant = q_q[24:2];
            e_n  = exp_q + 10'sd127;
        end else begin
            mant = q_q[23:1];
            e_n  = exp_q + 10'sd126;
        end
`ifdef DIVIDE_F32_RNE_EN
        guard    = q_q[25] ? q_q[1] : q_q[0];
        sticky   = (q_q[25] & q_q[0]) | (|rem_q);
        round_up = guard & (sticky | mant[0]);
`else
        round_up = 1'b0;
`endif
        mant_r = {1'b0, mant} + {23'd0, round_up};
        // A carry out of the mantissa leaves mant_r[22:0] at zero and bumps the exponent
        e_r    = e_n + $signed({9'd0, mant_r[23]});
        if (spec_q) begin
            packed_res = spec_val_q;
        end else if (e_r >= 10'sd255) begin
            packed_res = {sign_q, 8'hFF, 23'd0};
        end else if (e_r <= 10'sd0) begin
            packed_res = {sign_q, 31'd0};
        end else begin
            packed_res = {sign_q, e_r[7:0], mant_r[22:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        exp_d      = exp_q;
        mb_d       = mb_q;
        rem_d      = rem_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        rdy_d      = 1'b0;
        quo_d      = quo_q;
        unique case (state_q)
            StSetup: begin
                sign_d = num_q[31] ^ den_q[31];
                exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb});
                rem_d  = a_zero ? 25'd0 : {2'b01, num_q[22:0]};
                mb_d   = {1'b1, den_q[22:0]};
                q_d    = '0;
                cnt_d  = '0;
                spec_d = 1'b1;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    spec_val_d = 32'h7FC0_0000;
                end else if (a_inf || b_zero) begin
                    spec_val_d = {num_q[31] ^ den_q[31], 8'hFF, 23'd0};
                end else if (a_zero || b_inf) begin
                    spec_val_d = {num_q[31] ^ den_q[31], 31'd0};
                end else begin
                    spec_d     = 1'b0;
                    spec_val_d = 32'd0;
                end
                state_d = StDivide;
            end
            StDivide: begin
                q_d   = {q_q[24:0], sub_ok};
                rem_d = {(sub_ok ? diff[23:0] : rem_q[23:0]), 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                quo_d   = packed_res;
                rdy_d   = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                rdy_d = 1'b1;
            end
            default: state_d = StSetup;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StSetup;
            num_q      <= num;
            den_q      <= den;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'd0;
            exp_q      <= '0;
            mb_q       <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
            quo_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            exp_q      <= exp_d;
            mb_q       <= mb_d;
            rem_q      <= rem_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
            quo_q      <= quo_d;
        end
    end

    assign rdy = rdy_q;
    assign quo = quo_q;

endmodule

// File: tb/tb_divide_f32.sv
// Bench for divide_f32: cycle-level compare against an integer-arithmetic reference model,
// plus literal results for known operand pairs.
module tb_divide_f32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] num = 32'h40C0_0000;
    logic [31:0] den = 32'h4000_0000;
    logic        rdy;
    logic [31:0] quo;

    int n_vec  = 0;
    int n_fail = 0;

    divide_f32 u_dut (
        .clk (clk),
        .rst (rst),
        .num (num),
        .den (den),
        .rdy (rdy),
        .quo (quo)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int              ea, eb, e;
        logic            s, a_z, b_z, a_i, b_i, a_n, b_n, guard, sticky;
        longint unsigned ma, mb, qq, rr, mant;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        s   = a[31] ^ b[31];
        a_z = (ea == 0);
        b_z = (eb == 0);
        a_i = (ea == 255) && (a[22:0] == 23'd0);
        b_i = (eb == 255) && (b[22:0] == 23'd0);
        a_n = (ea == 255) && (a[22:0] != 23'd0);
        b_n = (eb == 255) && (b[22:0] != 23'd0);
        if (a_n || b_n || (a_z && b_z) || (a_i && b_i)) return 32'h7FC0_0000;
        if (a_i || b_z) return {s, 8'hFF, 23'd0};
        if (a_z || b_i) return {s, 31'd0};
        ma = 64'(a[22:0]) | 64'h80_0000;
        mb = 64'(b[22:0]) | 64'h80_0000;
        qq = (ma << 25) / mb;
        rr = (ma << 25) % mb;
        if (qq >= 64'h200_0000) begin
            mant   = (qq >> 2) & 64'h7F_FFFF;
            guard  = qq[1];
            sticky = qq[0] || (rr != 0);
            e      = ea - eb + 127;
        end else begin
            mant   = (qq >> 1) & 64'h7F_FFFF;
            guard  = qq[0];
            sticky = (rr != 0);
            e      = ea - eb + 126;
        end
`ifdef DIVIDE_F32_RNE_EN
        if (guard && (sticky || mant[0])) mant = mant + 1;
        if (mant == 64'h80_0000) begin
            mant = 0;
            e    = e + 1;
        end
`else
        guard  = 1'b0;
        sticky = guard;
`endif
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), mant[22:0]};
    endfunction

    // Latency model: result visible from the 28th non-reset edge after the last reset edge
    int          m_cnt = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_num, m_den;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   <= 0;
            m_num   <= num;
            m_den   <= den;
            m_valid <= 1'b1;
        end else if (m_cnt < 28) begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic        e_rdy;
        logic [31:0] e_quo;
        if (m_valid) begin
            e_rdy = (m_cnt >= 28);
            e_quo = e_rdy ? ref_div(m_num, m_den) : 32'd0;
            n_vec = n_vec + 1;
            if (rdy !== e_rdy || quo !== e_quo) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle_check t=%0t op=%h/%h rdy=%b quo=%h want rdy=%b quo=%h",
                         $time, m_num, m_den, rdy, quo, e_rdy, e_quo);
            end
        end
    end

    task automatic scramble();
        num = $urandom;
        den = $urandom;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        rst = 1'b1;
        num = a;
        den = b;
        @(posedge clk);
        #2;
        rst = 1'b0;
        scramble();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            scramble();
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] want);
        n_vec = n_vec + 1;
        if (rdy !== 1'b1 || quo !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: rdy=%b quo=%h want rdy=1 quo=%h", name, rdy, quo, want);
        end
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] want);
        start(a, b);
        run_cycles(28);
        check_lit(name, want);
        run_cycles(3);
        check_lit({name, "_hold"}, want);
    endtask

    function automatic logic [31:0] rnd_f();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 11))
            0:       v[30:0] = 31'd0;
            1:       v[30:0] = {8'hFF, 23'd0};
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = 8'h00;
            4:       v[30:23] = 8'($urandom_range(230, 254));
            5:       v[30:23] = 8'($urandom_range(1, 25));
            6:       v[22:0] = 23'h7F_FFFF;
            7:       v[22:0] = 23'd0;
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    initial begin
        directed("six_over_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
`ifdef DIVIDE_F32_RNE_EN
        directed("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
`else
        directed("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
`endif
        directed("neg8_half", 32'hC100_0000, 32'h3F00_0000, 32'hC180_0000);
        directed("one_over_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
        directed("zero_over_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
        directed("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000);
        directed("underflow", 32'h0080_0000, 32'h4200_0000, 32'h0000_0000);
        directed("inf_over_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);

        // Abort mid-operation: 6/2 replaced by 1/3 after 10 cycles
        start(32'h40C0_0000, 32'h4000_0000);
        run_cycles(10);
        start(32'h3F80_0000, 32'h4040_0000);
        run_cycles(28);
`ifdef DIVIDE_F32_RNE_EN
        check_lit("abort_restart", 32'h3EAA_AAAB);
`else
        check_lit("abort_restart", 32'h3EAA_AAAA);
`endif
        run_cycles(5);

        for (int k = 0; k < 250; k++) begin
            start(rnd_f(), rnd_f());
            if ($urandom_range(0, 9) == 0) begin
                run_cycles($urandom_range(0, 27));
                start(rnd_f(), rnd_f());
            end
            run_cycles(28 + $urandom_range(0, 3));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
